// File: rtl/cpu_io_host.sv
// Host-side endpoint for the pipelined CPU IO interface: launches a run, captures
// result words into a show-ahead FIFO and reports count, completion, overflow and timeout.
module cpu_io_host #(
  parameter int unsigned DATAWIDTH  = 25,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned COUNTWIDTH = 16,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [COUNTWIDTH-1:0] expectedWords,
  output logic                  startIO,
  input  logic                  outFlagIOWB,
  input  logic [DATAWIDTH-1:0]  cpuOut,
  output logic                  outValid,
  output logic [DATAWIDTH-1:0]  outData,
  input  logic                  outReady,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  timeoutErr,
  output logic [COUNTWIDTH-1:0] wordCount
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_COLLECT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [COUNTWIDTH-1:0] r_expected;
  logic [COUNTWIDTH-1:0] r_wordCount;
  logic [COUNTWIDTH-1:0] w_countInc;
  logic                  r_overflow;
  logic                  r_timeoutErr;
  logic [IW-1:0]         r_idle;
  logic [AW:0]           r_wptr;
  logic [AW:0]           r_rptr;
  logic [DATAWIDTH-1:0]  r_mem [DEPTH];
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_strobe;
  logic                  w_push;
  logic                  w_countHit;
  logic                  w_timeout;

  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop      = !w_empty && outReady;
  assign w_strobe   = (r_state == S_COLLECT) && outFlagIOWB;
  // A full FIFO still takes the word when the head leaves on the same edge.
  assign w_push     = w_strobe && (!w_full || w_pop);
  assign w_countInc = (&r_wordCount) ? r_wordCount : r_wordCount + COUNTWIDTH'(1);
  assign w_countHit = w_strobe && (w_countInc == r_expected);
  assign w_timeout  = (r_state == S_COLLECT) && !outFlagIOWB && (r_idle == IW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (expectedWords != '0) ? S_LAUNCH : S_DONE;
        end
      end
      S_LAUNCH:  w_next = S_COLLECT;
      S_COLLECT: begin
        if (w_countHit || w_timeout) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_empty) begin
          w_next = S_DONE;
        end
      end
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    startIO = (r_state == S_LAUNCH);
    busy    = (r_state != S_IDLE);
    done    = (r_state == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_expected   <= '0;
      r_wordCount  <= '0;
      r_overflow   <= 1'b0;
      r_timeoutErr <= 1'b0;
      r_idle       <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
    end else begin
      if ((r_state == S_IDLE) && start && (expectedWords != '0)) begin
        r_expected <= expectedWords;
      end
      if (r_state == S_LAUNCH) begin
        r_wordCount  <= '0;
        r_overflow   <= 1'b0;
        r_timeoutErr <= 1'b0;
        r_idle       <= '0;
        r_wptr       <= '0;
        r_rptr       <= '0;
      end else begin
        if (w_strobe) begin
          r_wordCount <= w_countInc;
          r_idle      <= '0;
          if (!w_push) begin
            r_overflow <= 1'b1;
          end
        end else if (r_state == S_COLLECT) begin
          r_idle <= r_idle + IW'(1);
          if (w_timeout && !w_countHit) begin
            r_timeoutErr <= 1'b1;
          end
        end
        if (w_push) begin
          r_wptr <= r_wptr + (AW + 1)'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + (AW + 1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= cpuOut;
    end
  end

  assign outValid   = !w_empty;
  assign outData    = r_mem[r_rptr[AW-1:0]];
  assign overflow   = r_overflow;
  assign timeoutErr = r_timeoutErr;
  assign wordCount  = r_wordCount;

endmodule

// File: tb/tb_cpu_io_host.sv
// Self-checking bench for cpu_io_host: directed scenarios plus randomized runs,
// checked every cycle against a queue-based behavioural model.
module tb_cpu_io_host;

  localparam int unsigned DW    = 25;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 16;
  localparam int unsigned TMO   = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] expectedWords;
  logic          startIO;
  logic          outFlagIOWB;
  logic [DW-1:0] cpuOut;
  logic          outValid;
  logic [DW-1:0] outData;
  logic          outReady;
  logic          busy;
  logic          done;
  logic          overflow;
  logic          timeoutErr;
  logic [CW-1:0] wordCount;

  int tests = 0;
  int fails = 0;

  cpu_io_host #(
    .DATAWIDTH (DW),
    .DEPTH     (DEPTH),
    .COUNTWIDTH(CW),
    .TIMEOUT   (TMO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .expectedWords(expectedWords),
    .startIO      (startIO),
    .outFlagIOWB  (outFlagIOWB),
    .cpuOut       (cpuOut),
    .outValid     (outValid),
    .outData      (outData),
    .outReady     (outReady),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .timeoutErr   (timeoutErr),
    .wordCount    (wordCount)
  );

  always #5 clock = ~clock;

  typedef enum {P_IDLE, P_LAUNCH, P_COLLECT, P_DRAIN, P_DONE} phase_t;
  phase_t        m_ph;
  logic [DW-1:0] m_q[$];
  int            m_cnt, m_exp, m_idle;
  bit            m_ovf, m_tmo;

  logic [DW-1:0] got[$];
  logic [DW-1:0] sent[$];
  int            n_startio, n_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the reference model across one rising edge using the current inputs.
  task automatic model_edge();
    bit pop;
    bit push;
    if (reset) begin
      m_q.delete();
      m_ph = P_IDLE; m_cnt = 0; m_ovf = 0; m_tmo = 0; m_idle = 0;
      return;
    end
    pop  = (m_q.size() != 0) && outReady;
    push = 0;
    case (m_ph)
      P_IDLE: if (start) begin
        if (expectedWords != 0) begin
          m_exp = int'(expectedWords);
          m_ph  = P_LAUNCH;
        end else begin
          m_ph = P_DONE;
        end
      end
      P_LAUNCH: begin
        m_q.delete(); pop = 0;
        m_cnt = 0; m_ovf = 0; m_tmo = 0; m_idle = 0;
        m_ph = P_COLLECT;
      end
      P_COLLECT: if (outFlagIOWB) begin
        if (m_cnt < 65535) m_cnt++;
        m_idle = 0;
        if (m_q.size() < DEPTH || pop) push = 1;
        else m_ovf = 1;
        if (m_cnt == m_exp) m_ph = P_DRAIN;
      end else begin
        m_idle++;
        if (m_idle == TMO) begin
          m_tmo = 1;
          m_ph  = P_DRAIN;
        end
      end
      P_DRAIN: if (m_q.size() == 0) m_ph = P_DONE;
      P_DONE:  m_ph = P_IDLE;
      default: m_ph = P_IDLE;
    endcase
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(cpuOut);
  endtask

  task automatic tick();
    if (!reset && outValid === 1'b1 && outReady) got.push_back(outData);
    model_edge();
    @(posedge clock);
    #1;
    chk("startIO",    32'(startIO),    32'(m_ph == P_LAUNCH));
    chk("busy",       32'(busy),       32'(m_ph != P_IDLE));
    chk("done",       32'(done),       32'(m_ph == P_DONE));
    chk("outValid",   32'(outValid),   32'(m_q.size() != 0));
    chk("overflow",   32'(overflow),   32'(m_ovf));
    chk("timeoutErr", 32'(timeoutErr), 32'(m_tmo));
    chk("wordCount",  32'(wordCount),  32'(m_cnt));
    if (m_q.size() != 0) chk("outData", 32'(outData), 32'(m_q[0]));
    if (startIO === 1'b1) n_startio++;
    if (done === 1'b1) n_done++;
  endtask

  task automatic launch(input int n);
    start = 1'b1;
    expectedWords = CW'(n);
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic strobe(input logic [DW-1:0] w);
    outFlagIOWB = 1'b1;
    cpuOut = w;
    sent.push_back(w);
    tick();
    outFlagIOWB = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done === 1'b1) seen = 1;
    end
    chk("done_within_budget", 32'(seen), 32'(1));
  endtask

  task automatic new_run();
    got.delete();
    sent.delete();
    n_startio = 0;
    n_done = 0;
  endtask

  task automatic compare_words(input string tag, input int n);
    chk({tag, "_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++) begin
      chk({tag, "_word"}, 32'(got[i]), 32'(sent[i]));
    end
  endtask

  task automatic basic_run(input string tag);
    new_run();
    outReady = 1'b1;
    launch(3);
    strobe(25'h0000001);
    strobe(25'h0ABCDEF);
    strobe(25'h1FFFFFF);
    wait_done(50);
    tick();
    compare_words(tag, 3);
    chk({tag, "_startio_pulses"}, 32'(n_startio), 32'(1));
    chk({tag, "_done_pulses"},    32'(n_done),    32'(1));
    chk({tag, "_wordCount"},      32'(wordCount), 32'(3));
    chk({tag, "_overflow"},       32'(overflow),  32'(0));
    chk({tag, "_timeoutErr"},     32'(timeoutErr), 32'(0));
    chk({tag, "_busy_after"},     32'(busy),      32'(0));
  endtask

  initial begin
    int k;
    reset = 1'b1; start = 1'b0; expectedWords = '0;
    outFlagIOWB = 1'b0; cpuOut = '0; outReady = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    basic_run("basic");

    // Backpressure: only the first DEPTH words survive.
    new_run();
    outReady = 1'b0;
    launch(10);
    for (int i = 0; i < 10; i++) strobe(DW'($urandom));
    chk("ovf_in_drain_busy", 32'(busy), 32'(1));
    chk("ovf_in_drain_valid", 32'(outValid), 32'(1));
    outReady = 1'b1;
    wait_done(50);
    chk("ovf_drained_before_done", 32'(got.size()), 32'(DEPTH));
    tick();
    compare_words("ovf", DEPTH);
    chk("ovf_flag",      32'(overflow),  32'(1));
    chk("ovf_wordCount", 32'(wordCount), 32'(10));
    chk("ovf_done",      32'(n_done),    32'(1));

    // Full FIFO with a pop on the same edge as a push.
    new_run();
    outReady = 1'b0;
    launch(9);
    for (int i = 0; i < 8; i++) strobe(DW'($urandom));
    outReady = 1'b1;
    strobe(DW'($urandom));
    chk("fullpop_overflow", 32'(overflow), 32'(0));
    wait_done(50);
    tick();
    compare_words("fullpop", 9);

    // Timeout latency measured from the last strobe.
    new_run();
    outReady = 1'b1;
    launch(5);
    strobe(DW'($urandom));
    strobe(DW'($urandom));
    k = 0;
    while (timeoutErr !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    chk("tmo_latency", 32'(k), 32'(TMO));
    chk("tmo_wordCount", 32'(wordCount), 32'(2));
    wait_done(50);
    tick();
    chk("tmo_done", 32'(n_done), 32'(1));
    chk("tmo_sticky", 32'(timeoutErr), 32'(1));

    // Zero-length request and strobes while idle.
    new_run();
    start = 1'b1; expectedWords = '0;
    tick();
    start = 1'b0;
    chk("zero_done", 32'(done), 32'(1));
    chk("zero_no_startio", 32'(startIO), 32'(0));
    chk("zero_keeps_tmo", 32'(timeoutErr), 32'(1));
    tick();
    outFlagIOWB = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpuOut = DW'($urandom);
      tick();
    end
    outFlagIOWB = 1'b0;
    chk("idle_strobe_count", 32'(wordCount), 32'(2));
    chk("idle_strobe_valid", 32'(outValid), 32'(0));

    // Reset in the middle of a run.
    new_run();
    outReady = 1'b0;
    launch(4);
    strobe(DW'($urandom));
    strobe(DW'($urandom));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_valid", 32'(outValid), 32'(0));
    chk("rst_busy",  32'(busy),     32'(0));
    chk("rst_count", 32'(wordCount), 32'(0));
    chk("rst_startio", 32'(startIO), 32'(0));
    tick();
    basic_run("post_reset");

    // Randomized runs; stray start pulses must be ignored while busy.
    for (int r = 0; r < 8; r++) begin
      int cyc;
      launch(int'($urandom_range(1, 12)));
      cyc = 0;
      while (busy === 1'b1 && cyc < 400) begin
        outFlagIOWB   = (r == 3) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) != 0);
        cpuOut        = DW'($urandom);
        outReady      = ($urandom_range(0, 2) != 0);
        start         = ($urandom_range(0, 4) == 0);
        expectedWords = CW'($urandom_range(0, 12));
        tick();
        cyc++;
      end
      start = 1'b0;
      outFlagIOWB = 1'b0;
      chk("rand_run_finished", 32'(busy), 32'(0));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
